// File: rtl/axis_num_check_if.sv
// AXI-Stream bundle carrying the mesh egress flits into axis_num_check.
// One valid/ready rule covers the link: a flit moves on a rising edge where tvalid && tready.
interface axis_num_check_if #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4
);
    logic              tvalid;
    logic              tready;
    logic [TDATAW-1:0] tdata;
    logic              tlast;
    logic [TDESTW-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tdest, output tready);
endinterface

// File: rtl/axis_num_check.sv
// Egress sink for num_gen traffic: regenerates the LFSR stream, checks data/dest/length,
// throttles TREADY from a rotating mask and keeps saturating status counters.
module axis_num_check #(
    parameter int                  TDATAW       = 32,
    parameter int                  TDESTW       = 4,
    parameter int                  LFSR_DW      = 16,
    parameter logic [LFSR_DW-1:0]  LFSR_DEFAULT = 16'hACE1,
    parameter logic [LFSR_DW-1:0]  LFSR_TAPS    = 16'hB400,
    parameter int                  PKT_LEN      = 4,
    parameter int                  NUM_PKTS     = 8,
    parameter int                  CNTW         = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ENABLE,
    input  logic              CLEAR,
    input  logic [TDESTW-1:0] MY_DEST,
    input  logic [7:0]        READY_MASK,
    axis_num_check_if.slave   axis_s,
    output logic [CNTW-1:0]   FLIT_COUNT,
    output logic [CNTW-1:0]   PKT_COUNT,
    output logic [CNTW-1:0]   DATA_ERR,
    output logic [CNTW-1:0]   LEN_ERR,
    output logic [CNTW-1:0]   DEST_ERR,
    output logic [TDATAW-1:0] FIRST_BAD,
    output logic              DONE,
    output logic [1:0]        DBG_STATE
);

    localparam int IDXW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              tready_q, tready_d;
    logic [2:0]        slot_q, slot_d;
    logic [LFSR_DW-1:0] lfsr_q, lfsr_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   flit_q, flit_d, pkt_q, pkt_d;
    logic [CNTW-1:0]   derr_q, derr_d, lerr_q, lerr_d, dsterr_q, dsterr_d;
    logic [TDATAW-1:0] first_bad_q, first_bad_d;
    logic [TDATAW-1:0] exp_data;
    logic              accept, done_hit, done_o;

    function automatic logic [LFSR_DW-1:0] lfsr_step(input logic [LFSR_DW-1:0] v);
        return {v[LFSR_DW-2:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    always_comb begin
        exp_data = '0;
        exp_data[LFSR_DW-1:0] = lfsr_q;
    end

    // TREADY is a register, so acceptance never depends combinationally on TVALID.
    assign accept   = axis_s.tvalid && tready_q && (state_q == S_ACTIVE);
    assign done_hit = accept && axis_s.tlast && (NUM_PKTS != 0) && (pkt_d == CNTW'(NUM_PKTS));

    // Check datapath: data resync, dest compare, length tracking, counters.
    always_comb begin
        lfsr_d      = lfsr_q;
        idx_d       = idx_q;
        flit_d      = flit_q;
        pkt_d       = pkt_q;
        derr_d      = derr_q;
        lerr_d      = lerr_q;
        dsterr_d    = dsterr_q;
        first_bad_d = first_bad_q;
        if (accept) begin
            flit_d = sat_inc(flit_q);
            if (axis_s.tdata != exp_data) begin
                derr_d = sat_inc(derr_q);
                if (derr_q == '0) first_bad_d = axis_s.tdata;
                lfsr_d = lfsr_step(axis_s.tdata[LFSR_DW-1:0]);
            end else begin
                lfsr_d = lfsr_step(lfsr_q);
            end
            if (axis_s.tdest != MY_DEST) dsterr_d = sat_inc(dsterr_q);
            if (axis_s.tlast) begin
                pkt_d = sat_inc(pkt_q);
                idx_d = '0;
                if (idx_q != IDX_LAST) lerr_d = sat_inc(lerr_q);
            end else if (idx_q == IDX_LAST) begin
                lerr_d = sat_inc(lerr_q);
                idx_d  = '0;
            end else begin
                idx_d = idx_q + IDXW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (ENABLE) state_d = S_ACTIVE;
            S_ACTIVE: begin
                if (done_hit)                      state_d = S_DONE;
                else if (!ENABLE && idx_d == '0)   state_d = S_IDLE;
            end
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Slot rotates every ACTIVE cycle; TREADY for the next cycle follows the mask bit of that slot.
    always_comb begin
        slot_d   = (state_q == S_ACTIVE) ? slot_q + 3'd1 : slot_q;
        tready_d = (state_d == S_ACTIVE) && READY_MASK[slot_d];
        done_o   = (state_q == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else if (CLEAR) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tready_q    <= 1'b0;
            slot_q      <= '0;
            lfsr_q      <= LFSR_DEFAULT;
            idx_q       <= '0;
            flit_q      <= '0;
            pkt_q       <= '0;
            derr_q      <= '0;
            lerr_q      <= '0;
            dsterr_q    <= '0;
            first_bad_q <= '0;
        end else if (CLEAR) begin
            tready_q    <= 1'b0;
            slot_q      <= '0;
            lfsr_q      <= LFSR_DEFAULT;
            idx_q       <= '0;
            flit_q      <= '0;
            pkt_q       <= '0;
            derr_q      <= '0;
            lerr_q      <= '0;
            dsterr_q    <= '0;
            first_bad_q <= '0;
        end else begin
            tready_q    <= tready_d;
            slot_q      <= slot_d;
            lfsr_q      <= lfsr_d;
            idx_q       <= idx_d;
            flit_q      <= flit_d;
            pkt_q       <= pkt_d;
            derr_q      <= derr_d;
            lerr_q      <= lerr_d;
            dsterr_q    <= dsterr_d;
            first_bad_q <= first_bad_d;
        end
    end

    assign axis_s.tready = tready_q;
    assign FLIT_COUNT    = flit_q;
    assign PKT_COUNT     = pkt_q;
    assign DATA_ERR      = derr_q;
    assign LEN_ERR       = lerr_q;
    assign DEST_ERR      = dsterr_q;
    assign FIRST_BAD     = first_bad_q;
    assign DONE          = done_o;
    assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_axis_num_check.sv
// Bench for axis_num_check: directed vector table, multi-cycle corner sequences and
// randomized num_gen-style traffic scored against a flit-level reference model.
module tb_axis_num_check;

    logic        CLK = 1'b0;
    logic        RST_N, ENABLE, CLEAR;
    logic [3:0]  MY_DEST;
    logic [7:0]  READY_MASK;
    logic [15:0] FLIT_COUNT, PKT_COUNT, DATA_ERR, LEN_ERR, DEST_ERR;
    logic [31:0] FIRST_BAD;
    logic        DONE;
    logic [1:0]  DBG_STATE;

    int tests_run = 0;
    int failed    = 0;

    axis_num_check_if #(.TDATAW(32), .TDESTW(4)) axis_if ();

    axis_num_check dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .CLEAR(CLEAR),
        .MY_DEST(MY_DEST), .READY_MASK(READY_MASK), .axis_s(axis_if),
        .FLIT_COUNT(FLIT_COUNT), .PKT_COUNT(PKT_COUNT), .DATA_ERR(DATA_ERR),
        .LEN_ERR(LEN_ERR), .DEST_ERR(DEST_ERR), .FIRST_BAD(FIRST_BAD),
        .DONE(DONE), .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  dest;
    } flit_t;

    logic [15:0] seq [0:63];
    logic [15:0] m_exp;
    int          m_pos;
    logic [31:0] m_flit, m_pkt, m_derr, m_lerr, m_dsterr, m_fb;
    logic [31:0] exp_q [$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    task automatic m_reset();
        m_exp = 16'hACE1; m_pos = 0;
        m_flit = 0; m_pkt = 0; m_derr = 0; m_lerr = 0; m_dsterr = 0; m_fb = 0;
    endtask

    task automatic m_accept(input flit_t f);
        m_flit++;
        if (f.data != {16'h0, m_exp}) begin
            if (m_derr == 0) m_fb = f.data;
            m_derr++;
            m_exp = lfsr_next(f.data[15:0]);
        end else begin
            m_exp = lfsr_next(m_exp);
        end
        if (f.dest != MY_DEST) m_dsterr++;
        if (f.last) begin
            m_pkt++;
            if (m_pos != 3) m_lerr++;
            m_pos = 0;
        end else if (m_pos == 3) begin
            m_lerr++;
            m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_counts(input string tag, input logic [31:0] f, input logic [31:0] p,
                                input logic [31:0] de, input logic [31:0] le,
                                input logic [31:0] ds, input logic [31:0] fb);
        check({tag, ".flit"},  FLIT_COUNT, f);
        check({tag, ".pkt"},   PKT_COUNT,  p);
        check({tag, ".derr"},  DATA_ERR,   de);
        check({tag, ".lerr"},  LEN_ERR,    le);
        check({tag, ".dsterr"}, DEST_ERR,  ds);
        check({tag, ".fbad"},  FIRST_BAD,  fb);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_flit(input flit_t f, input int budget, output bit ok, output int cyc);
        bit rdy;
        axis_if.tvalid = 1'b1;
        axis_if.tdata  = f.data;
        axis_if.tlast  = f.last;
        axis_if.tdest  = f.dest;
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < budget) begin
            rdy = axis_if.tready;
            @(negedge CLK);
            cyc++;
            if (rdy) ok = 1'b1;
        end
    endtask

    task automatic push_flit(input flit_t f, output int cyc);
        bit ok;
        send_flit(f, 200, ok, cyc);
        if (!ok) begin
            tests_run++; failed++;
            $display("FAIL accept_timeout: flit 0x%0h not taken in 200 cycles, need accepted", f.data);
        end else begin
            m_accept(f);
        end
    endtask

    task automatic idle_bus();
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
    endtask

    task automatic do_clear();
        idle_bus();
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        m_reset();
    endtask

    function automatic flit_t mkf(input logic [31:0] d, input logic l, input logic [3:0] dst);
        flit_t f;
        f.data = d; f.last = l; f.dest = dst;
        return f;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          clr;
        flit_t       f;
        logic [31:0] e_flit, e_pkt, e_derr, e_lerr, e_dst, e_fb;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mkv(input bit clr, input logic [31:0] d, input logic l, input logic [3:0] dst,
                                 input int ef, input int ep, input int ed, input int el, input int es,
                                 input logic [31:0] efb);
        vec_t v;
        v.clr = clr; v.f = mkf(d, l, dst);
        v.e_flit = ef; v.e_pkt = ep; v.e_derr = ed; v.e_lerr = el; v.e_dst = es; v.e_fb = efb;
        return v;
    endfunction

    function automatic logic [31:0] S(input int i);
        return {16'h0, seq[i]};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int    cyc, tot;
        bit    ok;
        flit_t f;

        seq[0] = 16'hACE1;
        for (int i = 1; i < 64; i++) seq[i] = lfsr_next(seq[i-1]);
        m_reset();

        RST_N = 1'b0; ENABLE = 1'b0; CLEAR = 1'b0; MY_DEST = 4'd0; READY_MASK = 8'hFF;
        axis_if.tvalid = 1'b0; axis_if.tdata = '0; axis_if.tlast = 1'b0; axis_if.tdest = '0;
        repeat (3) @(negedge CLK);
        check("rst.tready", axis_if.tready, 0);
        check("rst.done", DONE, 0);
        check_counts("rst", 0, 0, 0, 0, 0, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        ENABLE = 1'b1;

        // Full-rate: two clean packets, one flit per cycle.
        cyc = 0;
        while (!axis_if.tready && cyc < 20) begin @(negedge CLK); cyc++; end
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            push_flit(mkf(S(i), i % 4 == 3, 4'd0), cyc);
            tot += cyc;
        end
        idle_bus();
        check("fullrate.cycles", tot, 8);
        check_counts("fullrate", 8, 2, 0, 0, 0, 0);

        // Alternating backpressure: TREADY follows the mask slot by slot.
        READY_MASK = 8'b0101_0101;
        do_clear();
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check($sformatf("mask55.tready%0d", k), axis_if.tready, (k % 2 == 0) ? 1 : 0);
        end
        for (int i = 0; i < 8; i++) push_flit(mkf(S(i), i % 4 == 3, 4'd0), cyc);
        idle_bus();
        check_counts("mask55", 8, 2, 0, 0, 0, 0);

        // Table: corrupt flit with resync, length violations, combined errors.
        vecs.push_back(mkv(1, S(0), 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, S(1), 0, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 32'hDEAD, 0, 0, 3, 0, 1, 0, 0, 32'hDEAD));
        vecs.push_back(mkv(0, S(3), 1, 0, 4, 1, 2, 0, 0, 32'hDEAD));
        vecs.push_back(mkv(0, S(4), 0, 0, 5, 1, 2, 0, 0, 32'hDEAD));
        vecs.push_back(mkv(0, S(5), 0, 0, 6, 1, 2, 0, 0, 32'hDEAD));
        vecs.push_back(mkv(0, S(6), 0, 0, 7, 1, 2, 0, 0, 32'hDEAD));
        vecs.push_back(mkv(0, S(7), 1, 0, 8, 2, 2, 0, 0, 32'hDEAD));
        vecs.push_back(mkv(1, S(0), 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, S(1), 1, 0, 2, 1, 0, 1, 0, 0));
        vecs.push_back(mkv(0, S(2), 0, 0, 3, 1, 0, 1, 0, 0));
        vecs.push_back(mkv(0, S(3), 0, 0, 4, 1, 0, 1, 0, 0));
        vecs.push_back(mkv(0, S(4), 0, 0, 5, 1, 0, 1, 0, 0));
        vecs.push_back(mkv(0, S(5), 0, 0, 6, 1, 0, 2, 0, 0));
        vecs.push_back(mkv(0, S(6), 0, 0, 7, 1, 0, 2, 0, 0));
        vecs.push_back(mkv(0, S(7), 0, 0, 8, 1, 0, 2, 0, 0));
        vecs.push_back(mkv(0, S(8), 0, 5, 9, 1, 0, 2, 1, 0));
        vecs.push_back(mkv(0, S(9), 1, 0, 10, 2, 0, 2, 1, 0));
        vecs.push_back(mkv(1, 32'h1234, 1, 3, 1, 1, 1, 1, 1, 32'h1234));
        vecs.push_back(mkv(0, S(1), 0, 0, 2, 1, 2, 1, 1, 32'h1234));

        READY_MASK = 8'hFF;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].clr) do_clear();
            push_flit(vecs[i].f, cyc);
            check_counts($sformatf("vec%0d", i), vecs[i].e_flit, vecs[i].e_pkt, vecs[i].e_derr,
                         vecs[i].e_lerr, vecs[i].e_dst, vecs[i].e_fb);
        end
        idle_bus();

        // DONE after the 8th TLAST; a 9th packet is never accepted; CLEAR recovers.
        do_clear();
        for (int i = 0; i < 32; i++) push_flit(mkf(S(i), i % 4 == 3, 4'd0), cyc);
        check("done.flag", DONE, 1);
        check("done.tready", axis_if.tready, 0);
        check_counts("done", 32, 8, 0, 0, 0, 0);
        send_flit(mkf(S(32), 1'b0, 4'd0), 20, ok, cyc);
        check("done.no_accept", ok, 0);
        idle_bus();
        check("done.flit_hold", FLIT_COUNT, 32);
        do_clear();
        check("clear.done", DONE, 0);
        check_counts("clear", 0, 0, 0, 0, 0, 0);

        // Async reset mid-packet, then a fresh clean packet.
        push_flit(mkf(S(0), 1'b0, 4'd0), cyc);
        push_flit(mkf(S(1), 1'b0, 4'd0), cyc);
        axis_if.tvalid = 1'b1; axis_if.tdata = S(2);
        #2 RST_N = 1'b0;
        #1;
        check("arst.tready", axis_if.tready, 0);
        check("arst.flit", FLIT_COUNT, 0);
        @(negedge CLK);
        idle_bus();
        RST_N = 1'b1;
        m_reset();
        @(negedge CLK);
        for (int i = 0; i < 4; i++) push_flit(mkf(S(i), i == 3, 4'd0), cyc);
        idle_bus();
        check_counts("arst_after", 4, 1, 0, 0, 0, 0);

        // Randomized num_gen-style traffic with injected faults.
        for (int r = 0; r < 20; r++) begin
            logic [15:0] tx;
            int          pos, lasts, nfl;
            READY_MASK = 8'($urandom_range(1, 255));
            MY_DEST    = 4'($urandom_range(0, 15));
            do_clear();
            tx = 16'hACE1; pos = 0; lasts = 0;
            nfl = $urandom_range(4, 28);
            for (int i = 0; i < nfl && lasts < 7; i++) begin
                f.data = {16'h0, tx};
                tx = lfsr_next(tx);
                if ($urandom_range(0, 7) == 0) f.data = $urandom;
                f.dest = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : MY_DEST;
                f.last = (pos == 3);
                if ($urandom_range(0, 7) == 0) f.last = ~f.last;
                pos = (pos == 3) ? 0 : pos + 1;
                if (f.last) lasts++;
                push_flit(f, cyc);
                if ($urandom_range(0, 3) == 0) begin
                    idle_bus();
                    repeat ($urandom_range(1, 3)) @(negedge CLK);
                end
            end
            idle_bus();
            exp_q.push_back(m_flit); exp_q.push_back(m_pkt); exp_q.push_back(m_derr);
            exp_q.push_back(m_lerr); exp_q.push_back(m_dsterr); exp_q.push_back(m_fb);
            check($sformatf("rnd%0d.flit", r),   FLIT_COUNT, exp_q.pop_front());
            check($sformatf("rnd%0d.pkt", r),    PKT_COUNT,  exp_q.pop_front());
            check($sformatf("rnd%0d.derr", r),   DATA_ERR,   exp_q.pop_front());
            check($sformatf("rnd%0d.lerr", r),   LEN_ERR,    exp_q.pop_front());
            check($sformatf("rnd%0d.dsterr", r), DEST_ERR,   exp_q.pop_front());
            check($sformatf("rnd%0d.fbad", r),   FIRST_BAD,  exp_q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
